// File: rtl/memwb_pkg.sv
// Shared definitions for the MEM/WB pipeline register.
//   CTRL_*           : bit positions within the control bus
//   MEMWB_MAX_STAGES : upper bound on the number of register slices
//   memwb_slice_t    : stage slice layout {valid, word, byte, ctrl, rd} at the
//                      default widths (W=16, B=8, C=4, RW=3); other widths keep
//                      the same field order
//   slice_width()    : packed width of one slice for given field widths
package memwb_pkg;

    localparam int unsigned CTRL_REGWR       = 0;
    localparam int unsigned CTRL_BYTESEL     = 1;
    localparam int unsigned CTRL_SEXT        = 2;
    localparam int unsigned MEMWB_MAX_STAGES = 4;

    typedef struct packed {
        logic        valid;
        logic [15:0] word;
        logic [7:0]  mbyte;
        logic [3:0]  ctrl;
        logic [2:0]  rd;
    } memwb_slice_t;

    function automatic int unsigned slice_width(int unsigned w, int unsigned b,
                                                int unsigned c, int unsigned rw);
        return 1 + w + b + c + rw;
    endfunction

endpackage

// File: rtl/memwb_slice.sv
// One MEM/WB register slice.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   flush    : clear the slice to zero (wins over stall)
//   stall    : hold the current contents
//   d        : packed slice from the previous stage
//   q        : registered slice
module memwb_slice #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] q_d;
    logic [Width-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (flush) begin
            q_d = '0;
        end else if (!stall) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with STAGES clocked slices, valid bit, stall/flush,
// write-back data selection and a forwarding port taken from the last slice.
//   in_*      : MEM-stage result (valid, word, loaded byte, control, rd)
//   stall     : hold every slice, input dropped
//   flush     : clear every slice (beats stall)
//   out_*     : last-slice contents
//   wb_en/wb_data    : register-file write port
//   fwd_valid/rd/data: same-cycle copy of the write for EX forwarding
// Optional build macro MEMWB_STALL_CNT_EN adds stall_cnt[15:0], a saturating
// count of stalled (non-flushed) edges cleared only by rst.
module memwb_pipe_reg
    import memwb_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned B      = 8,
    parameter int unsigned C      = 4,
    parameter int unsigned RW     = 3,
    parameter int unsigned STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_word,
    input  logic [B-1:0]  in_byte,
    input  logic [C-1:0]  in_ctrl,
    input  logic [RW-1:0] in_rd,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [W-1:0]  out_word,
    output logic [B-1:0]  out_byte,
    output logic [C-1:0]  out_ctrl,
    output logic [RW-1:0] out_rd,
    output logic          wb_en,
    output logic [W-1:0]  wb_data,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_rd,
    output logic [W-1:0]  fwd_data
`ifdef MEMWB_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    typedef struct packed {
        logic          valid;
        logic [W-1:0]  word;
        logic [B-1:0]  mbyte;
        logic [C-1:0]  ctrl;
        logic [RW-1:0] rd;
    } slice_t;

    localparam int unsigned SliceW = slice_width(W, B, C, RW);

    if (STAGES < 1 || STAGES > MEMWB_MAX_STAGES || W < 8 || B > W || C < 3) begin : g_bad_cfg
        $error("memwb_pipe_reg: unsupported parameter combination");
    end

    slice_t stage_in;
    slice_t chain [STAGES+1];
    slice_t last;

    // Invalid input loads an all-zero bubble so stale payload never leaks out.
    always_comb begin
        stage_in = '0;
        if (in_valid) begin
            stage_in.valid = 1'b1;
            stage_in.word  = in_word;
            stage_in.mbyte = in_byte;
            stage_in.ctrl  = in_ctrl;
            stage_in.rd    = in_rd;
        end
    end

    assign chain[0] = stage_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        memwb_slice #(
            .Width(SliceW)
        ) u_slice (
            .clk  (clk),
            .rst  (rst),
            .flush(flush),
            .stall(stall),
            .d    (chain[k]),
            .q    (chain[k+1])
        );
    end

    assign last      = chain[STAGES];
    assign out_valid = last.valid;
    assign out_word  = last.word;
    assign out_byte  = last.mbyte;
    assign out_ctrl  = last.ctrl;
    assign out_rd    = last.rd;

    logic [W-1:0] byte_ext;

    if (B == W) begin : g_byte_full
        assign byte_ext = last.mbyte;
    end else begin : g_byte_ext
        assign byte_ext = last.ctrl[CTRL_SEXT] ? {{(W-B){last.mbyte[B-1]}}, last.mbyte}
                                               : {{(W-B){1'b0}}, last.mbyte};
    end

    assign wb_data = last.ctrl[CTRL_BYTESEL] ? byte_ext : last.word;
    // r0 is hard-wired zero, so a write to it is suppressed here.
    assign wb_en   = last.valid & last.ctrl[CTRL_REGWR] & (|last.rd);

    assign fwd_valid = wb_en;
    assign fwd_rd    = last.rd;
    assign fwd_data  = wb_data;

`ifdef MEMWB_STALL_CNT_EN
    logic [15:0] stall_cnt_d;
    logic [15:0] stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Bench for memwb_pipe_reg: one instance with STAGES=1 (dut_a) and one with
// STAGES=3 (dut_b) share the same stimulus. A queue-per-instance model tracks
// what each pipeline holds; expected write-back values come from arithmetic on
// the modelled entry.
module tb_memwb_pipe_reg;
    import memwb_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned B  = 8;
    localparam int unsigned C  = 4;
    localparam int unsigned RW = 3;

    typedef memwb_slice_t ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_word;
    logic [B-1:0]  in_byte;
    logic [C-1:0]  in_ctrl;
    logic [RW-1:0] in_rd;
    logic          stall;
    logic          flush;

    logic a_valid, a_wb_en, a_fwd_valid;
    logic [W-1:0] a_word, a_wb_data, a_fwd_data;
    logic [B-1:0] a_byte;
    logic [C-1:0] a_ctrl;
    logic [RW-1:0] a_rd, a_fwd_rd;
    logic b_valid, b_wb_en, b_fwd_valid;
    logic [W-1:0] b_word, b_wb_data, b_fwd_data;
    logic [B-1:0] b_byte;
    logic [C-1:0] b_ctrl;
    logic [RW-1:0] b_rd, b_fwd_rd;
`ifdef MEMWB_STALL_CNT_EN
    logic [15:0] a_cnt, b_cnt;
    int exp_cnt;
`endif

    always #5 clk = ~clk;

    memwb_pipe_reg #(.W(W), .B(B), .C(C), .RW(RW), .STAGES(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_byte(in_byte),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .stall(stall), .flush(flush),
        .out_valid(a_valid), .out_word(a_word), .out_byte(a_byte), .out_ctrl(a_ctrl),
        .out_rd(a_rd), .wb_en(a_wb_en), .wb_data(a_wb_data), .fwd_valid(a_fwd_valid),
        .fwd_rd(a_fwd_rd), .fwd_data(a_fwd_data)
`ifdef MEMWB_STALL_CNT_EN
        , .stall_cnt(a_cnt)
`endif
    );

    memwb_pipe_reg #(.W(W), .B(B), .C(C), .RW(RW), .STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_byte(in_byte),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .stall(stall), .flush(flush),
        .out_valid(b_valid), .out_word(b_word), .out_byte(b_byte), .out_ctrl(b_ctrl),
        .out_rd(b_rd), .wb_en(b_wb_en), .wb_data(b_wb_data), .fwd_valid(b_fwd_valid),
        .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data)
`ifdef MEMWB_STALL_CNT_EN
        , .stall_cnt(b_cnt)
`endif
    );

    ent_t pipe_a[$];
    ent_t pipe_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void model_reset();
        pipe_a.delete();
        pipe_b.delete();
        pipe_a.push_back('0);
        repeat (3) pipe_b.push_back('0);
`ifdef MEMWB_STALL_CNT_EN
        exp_cnt = 0;
`endif
    endfunction

    // Model of one rising edge, using the inputs as they stand at the edge.
    function automatic void model_edge();
        ent_t e;
        e = '0;
        if (in_valid) begin
            e.valid = 1'b1;
            e.word  = in_word;
            e.mbyte = in_byte;
            e.ctrl  = in_ctrl;
            e.rd    = in_rd;
        end
        if (rst) begin
            model_reset();
        end else if (flush) begin
            foreach (pipe_a[i]) pipe_a[i] = '0;
            foreach (pipe_b[i]) pipe_b[i] = '0;
        end else if (!stall) begin
            pipe_a.push_front(e);
            void'(pipe_a.pop_back());
            pipe_b.push_front(e);
            void'(pipe_b.pop_back());
        end
`ifdef MEMWB_STALL_CNT_EN
        if (!rst && stall && !flush && exp_cnt < 65535) exp_cnt++;
`endif
    endfunction

    // Full expected output vector for an entry sitting in the last slice.
    function automatic logic [127:0] expect_vec(ent_t e);
        logic [W-1:0] data;
        logic         en;
        if (!e.ctrl[1])     data = e.word;
        else if (e.ctrl[2]) data = W'($signed(e.mbyte));
        else                data = W'(e.mbyte);
        en = e.valid && e.ctrl[0] && (e.rd != 0);
        return 128'({e, en, data, en, e.rd, data});
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic check_model(input string name);
        chk({name, "/s1"}, 128'({a_valid, a_word, a_byte, a_ctrl, a_rd, a_wb_en, a_wb_data,
                                 a_fwd_valid, a_fwd_rd, a_fwd_data}), expect_vec(pipe_a[$]));
        chk({name, "/s3"}, 128'({b_valid, b_word, b_byte, b_ctrl, b_rd, b_wb_en, b_wb_data,
                                 b_fwd_valid, b_fwd_rd, b_fwd_data}), expect_vec(pipe_b[$]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] w, input logic [B-1:0] b,
                         input logic [C-1:0] c, input logic [RW-1:0] rd);
        in_valid = v;
        in_word  = w;
        in_byte  = b;
        in_ctrl  = c;
        in_rd    = rd;
    endtask

    typedef struct {
        logic          v;
        logic [W-1:0]  w;
        logic [B-1:0]  b;
        logic [C-1:0]  c;
        logic [RW-1:0] rd;
        logic          exp_en;
        logic [W-1:0]  exp_data;
        logic [RW-1:0] exp_rd;
    } tv_t;

    tv_t tv [9];
    int  cycles;

    initial begin
        tv[0] = '{1'b1, 16'h1234, 8'h00, 4'b0001, 3'd3, 1'b1, 16'h1234, 3'd3};
        tv[1] = '{1'b1, 16'hAAAA, 8'h9C, 4'b0111, 3'd2, 1'b1, 16'hFF9C, 3'd2};
        tv[2] = '{1'b1, 16'hAAAA, 8'h9C, 4'b0011, 3'd2, 1'b1, 16'h009C, 3'd2};
        tv[3] = '{1'b1, 16'h0000, 8'h7F, 4'b0111, 3'd1, 1'b1, 16'h007F, 3'd1};
        tv[4] = '{1'b1, 16'h5555, 8'h11, 4'b0001, 3'd0, 1'b0, 16'h5555, 3'd0};
        tv[5] = '{1'b0, 16'hFFFF, 8'hFF, 4'b0001, 3'd4, 1'b0, 16'h0000, 3'd0};
        tv[6] = '{1'b1, 16'hBEEF, 8'h00, 4'b1001, 3'd7, 1'b1, 16'hBEEF, 3'd7};
        tv[7] = '{1'b1, 16'h1111, 8'h22, 4'b0000, 3'd6, 1'b0, 16'h1111, 3'd6};
        tv[8] = '{1'b1, 16'h4321, 8'h80, 4'b0101, 3'd2, 1'b1, 16'h4321, 3'd2};

        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 16'hDEAD, 8'hBE, 4'b0001, 3'd1);
        model_reset();
        #2;
        check_model("in_reset");
        step();
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        step();
        check_model("after_reset");

        // Directed vectors against the single-slice instance.
        for (int i = 0; i < 9; i++) begin
            drive(tv[i].v, tv[i].w, tv[i].b, tv[i].c, tv[i].rd);
            step();
            chk($sformatf("vec%0d_wb", i),
                128'({a_wb_en, a_wb_data, a_fwd_valid, a_fwd_rd, a_fwd_data}),
                128'({tv[i].exp_en, tv[i].exp_data, tv[i].exp_en, tv[i].exp_rd, tv[i].exp_data}));
            check_model($sformatf("vec%0d", i));
        end

        // Bubbles reach the end of the three-slice pipe as zeros.
        drive(1'b0, 16'hFFFF, 8'hFF, 4'b1111, 3'd7);
        repeat (3) step();
        chk("bubble_s3", 128'({b_valid, b_word}), 128'(0));

        // Stall holds the entry at the output with wb_en kept high.
        drive(1'b1, 16'h0555, 8'h00, 4'b0001, 3'd5);
        step();
        stall = 1'b1;
        drive(1'b1, 16'h7777, 8'h00, 4'b0001, 3'd7);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("stall_hold%0d", i), 128'({a_valid, a_rd, a_wb_en, a_word}),
                128'({1'b1, 3'd5, 1'b1, 16'h0555}));
            check_model("stall");
        end
        flush = 1'b1;
        step();
        chk("flush_over_stall", 128'({a_valid, a_wb_en, a_fwd_valid}), 128'(0));
        check_model("flush");
        flush = 1'b0;
        stall = 1'b0;

        // Asynchronous reset with three entries in flight.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, W'(16'h0100 * i), 8'h00, 4'b0001, RW'(i));
            step();
        end
        check_model("inflight");
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_model("async_reset");
        step();
        rst = 1'b0;
        drive(1'b1, 16'hCAFE, 8'h00, 4'b0001, 3'd4);
        cycles = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cycles++;
            drive(1'b0, '0, '0, '0, '0);
            if (b_valid) break;
        end
        chk("reset_latency", 128'(cycles), 128'(3));
        chk("reset_first_word", 128'({b_valid, b_word, b_rd}), 128'({1'b1, 16'hCAFE, 3'd4}));

        // Randomised traffic with occasional stall and flush.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, W'($urandom), B'($urandom), C'($urandom),
                  RW'($urandom));
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 15) == 0);
            step();
            check_model($sformatf("rand%0d", i));
        end
        stall = 1'b0;
        flush = 1'b0;

`ifdef MEMWB_STALL_CNT_EN
        chk("cnt_rand_a", 128'(a_cnt), 128'(exp_cnt));
        chk("cnt_rand_b", 128'(b_cnt), 128'(exp_cnt));
        #2;
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            step();
        end
        flush = 1'b0;
        chk("cnt_flush_skip", 128'(a_cnt), 128'(16'd4));
        repeat (65530) step();
        chk("cnt_preload", 128'(a_cnt), 128'(16'hFFFE));
        repeat (3) step();
        chk("cnt_saturate", 128'(a_cnt), 128'(16'hFFFF));
        chk("cnt_saturate_b", 128'(b_cnt), 128'(16'hFFFF));
        stall = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
